wb_regfile: RTL and testbench

- Consumes the MEM/WB pipeline register outputs and implements the WB stage.
- Selects the write-back source, formats load data, and writes the 32x32 integer register file.
- Provides two ID-stage read ports, with same-cycle write-through bypass.
- Keeps a retired-instruction counter for the future CSR block.

---
 rtl/rv_pkg.sv | 19 +
 rtl/load_formatter.sv | 39 +++
 rtl/wb_regfile.sv | 82 ++++++++
 tb/tb_wb_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: write-back select codes, load funct3 codes, data width.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_ZERO = 2'b11
  } wb_sel_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/halfword from a raw aligned memory word.
module load_formatter
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Pick the addressed byte and halfword (little-endian lanes).
  always_comb begin
    byte_val = raw[7:0];
    case (off)
      2'd0:    byte_val = raw[7:0];
      2'd1:    byte_val = raw[15:8];
      2'd2:    byte_val = raw[23:16];
      default: byte_val = raw[31:24];
    endcase
    half_val = off[1] ? raw[31:16] : raw[15:0];
  end

  // Extend according to load size/sign; unknown codes pass the raw word.
  always_comb begin
    data = raw;
    case (funct3)
      FUNCT3_LB:  data = {{24{byte_val[7]}}, byte_val};
      FUNCT3_LBU: data = {24'b0, byte_val};
      FUNCT3_LH:  data = {{16{half_val[15]}}, half_val};
      FUNCT3_LHU: data = {16'b0, half_val};
      FUNCT3_LW:  data = raw;
      default:    data = raw;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// WB stage: write-back mux, 32x32 integer register file with write-through read bypass,
// and retired-instruction counter.
module wb_regfile
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [1:0]       wb_mem_to_reg,
  input  logic             wb_reg_write_en,
  input  logic [XLEN-1:0]  wb_dmem_data_out,
  input  logic [XLEN-1:0]  wb_alu_result,
  input  logic [XLEN-1:0]  wb_pc_plus4,
  input  logic [2:0]       wb_funct3,
  input  logic [4:0]       wb_rd_addr,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  output logic [XLEN-1:0]  id_rs1_data,
  output logic [XLEN-1:0]  id_rs2_data,
  output logic [XLEN-1:0]  wb_rd_data,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] load_data;
  logic            write_hit;

  load_formatter u_load_fmt (
    .raw    (wb_dmem_data_out),
    .off    (wb_alu_result[1:0]),
    .funct3 (wb_funct3),
    .data   (load_data)
  );

  assign write_hit = wb_reg_write_en && (wb_rd_addr != '0);

  // Select the write-back value.
  always_comb begin
    wb_rd_data = '0;
    case (wb_sel_e'(wb_mem_to_reg))
      WB_SEL_ALU:  wb_rd_data = wb_alu_result;
      WB_SEL_MEM:  wb_rd_data = load_data;
      WB_SEL_PC4:  wb_rd_data = wb_pc_plus4;
      WB_SEL_ZERO: wb_rd_data = '0;
      default:     wb_rd_data = '0;
    endcase
  end

  // Register storage; x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[wb_rd_addr] <= wb_rd_data;
    end
  end

  // Read port 1 with write-first bypass; x0 forced to zero.
  always_comb begin
    id_rs1_data = '0;
    if (write_hit && (wb_rd_addr == id_rs1_addr)) id_rs1_data = wb_rd_data;
    else if (id_rs1_addr != '0)                   id_rs1_data = regs[id_rs1_addr];
  end

  // Read port 2 with write-first bypass; x0 forced to zero.
  always_comb begin
    id_rs2_data = '0;
    if (write_hit && (wb_rd_addr == id_rs2_addr)) id_rs2_data = wb_rd_data;
    else if (id_rs2_addr != '0)                   id_rs2_data = regs[id_rs2_addr];
  end

  // Count retiring instructions; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           instret <= '0;
    else if (wb_valid) instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [1:0]  wb_mem_to_reg;
  logic        wb_reg_write_en;
  logic [31:0] wb_dmem_data_out;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc_plus4;
  logic [2:0]  wb_funct3;
  logic [4:0]  wb_rd_addr;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] wb_rd_data;
  logic [63:0] instret;

  wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid         (wb_valid),
    .wb_mem_to_reg    (wb_mem_to_reg),
    .wb_reg_write_en  (wb_reg_write_en),
    .wb_dmem_data_out (wb_dmem_data_out),
    .wb_alu_result    (wb_alu_result),
    .wb_pc_plus4      (wb_pc_plus4),
    .wb_funct3        (wb_funct3),
    .wb_rd_addr       (wb_rd_addr),
    .id_rs1_addr      (id_rs1_addr),
    .id_rs2_addr      (id_rs2_addr),
    .id_rs1_data      (id_rs1_data),
    .id_rs2_data      (id_rs2_data),
    .wb_rd_data       (wb_rd_data),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [32];
  logic [63:0] minst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] b;
    logic [31:0] h;
    b = (raw >> (8 * off)) & 32'h0000_00FF;
    h = (raw >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [31:0] exp_wb();
    case (wb_mem_to_reg)
      2'b00:   return wb_alu_result;
      2'b01:   return fmt_load(wb_dmem_data_out, wb_alu_result[1:0], wb_funct3);
      2'b10:   return wb_pc_plus4;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (wb_reg_write_en && wb_rd_addr == rs) return exp_wb();
    return mregs[rs];
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic we,
                       input logic [31:0] raw, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    wb_valid         = v;
    wb_mem_to_reg    = sel;
    wb_reg_write_en  = we;
    wb_dmem_data_out = raw;
    wb_alu_result    = alu;
    wb_pc_plus4      = pc4;
    wb_funct3        = f3;
    wb_rd_addr       = rd;
    id_rs1_addr      = rs1;
    id_rs2_addr      = rs2;
  endtask

  // Called at posedge+1 with inputs applied; checks outputs, then advances one clock.
  task automatic step(input string tag, input bit has_k, input logic [31:0] k);
    logic [31:0] w;
    #3;
    w = exp_wb();
    check({tag, "_rd"},   wb_rd_data,  w);
    check({tag, "_rs1"},  id_rs1_data, exp_read(id_rs1_addr));
    check({tag, "_rs2"},  id_rs2_data, exp_read(id_rs2_addr));
    check({tag, "_inst"}, instret,     minst);
    if (has_k) check({tag, "_k"}, wb_rd_data, k);
    @(posedge clk);
    if (wb_reg_write_en && wb_rd_addr != 5'd0) mregs[wb_rd_addr] = w;
    if (wb_valid) minst = minst + 64'd1;
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    minst = 64'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_inst", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 5'd0, 5'd0);
    #12;
    // Everything reads zero while held in reset.
    for (int i = 0; i < 32; i++) begin
      id_rs1_addr = 5'(i);
      id_rs2_addr = 5'(31 - i);
      #1;
      check("reset_rs1", id_rs1_data, 32'h0);
      check("reset_rs2", id_rs2_data, 32'h0);
    end
    check("reset_inst", instret, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write x5 with same-cycle bypass, then read from storage.
    drive(1'b1, 2'b00, 1'b1, 32'h0, 32'hDEADBEEF, 32'h0, 3'b000, 5'd5, 5'd5, 5'd5);
    step("x5_byp", 1'b1, 32'hDEADBEEF);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd5, 5'd5, 5'd0);
    step("x5_hold", 1'b0, 32'h0);
    check("x5_direct", id_rs1_data, 32'hDEADBEEF);

    // x0 write is dropped and never bypassed.
    drive(1'b1, 2'b00, 1'b1, 32'h0, 32'h12345678, 32'h0, 3'b000, 5'd0, 5'd0, 5'd5);
    step("x0_wr", 1'b1, 32'h12345678);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 5'd0, 5'd5);
    step("x0_rd", 1'b0, 32'h0);

    // Load formatting on 0x8081F27F.
    drive(1'b1, 2'b01, 1'b1, 32'h8081F27F, 32'h103, 32'h0, 3'b000, 5'd10, 5'd10, 5'd5);
    step("lb3", 1'b1, 32'hFFFFFF80);
    drive(1'b1, 2'b01, 1'b1, 32'h8081F27F, 32'h103, 32'h0, 3'b100, 5'd11, 5'd11, 5'd10);
    step("lbu3", 1'b1, 32'h00000080);
    drive(1'b1, 2'b01, 1'b1, 32'h8081F27F, 32'h102, 32'h0, 3'b001, 5'd12, 5'd12, 5'd11);
    step("lh2", 1'b1, 32'hFFFF8081);
    drive(1'b1, 2'b01, 1'b1, 32'h8081F27F, 32'h100, 32'h0, 3'b101, 5'd13, 5'd13, 5'd12);
    step("lhu0", 1'b1, 32'h0000F27F);
    drive(1'b1, 2'b01, 1'b1, 32'h8081F27F, 32'h101, 32'h0, 3'b010, 5'd14, 5'd14, 5'd13);
    step("lw", 1'b1, 32'h8081F27F);

    // Link value and zero select.
    drive(1'b1, 2'b10, 1'b1, 32'h0, 32'hFFFF, 32'h104, 3'b000, 5'd1, 5'd0, 5'd0);
    step("pc4", 1'b1, 32'h104);
    drive(1'b1, 2'b00, 1'b1, 32'h0, 32'hCAFE, 32'h0, 3'b000, 5'd2, 5'd1, 5'd0);
    step("x2_set", 1'b0, 32'h0);
    drive(1'b1, 2'b11, 1'b1, 32'hFFFFFFFF, 32'hCAFE, 32'h200, 3'b010, 5'd2, 5'd1, 5'd2);
    step("zero", 1'b1, 32'h0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 5'd1, 5'd2);
    step("x1x2_rd", 1'b0, 32'h0);

    // Counter over a 5-instruction burst, then async reset with a pending write.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 1'b0, 32'h0, 32'(i), 32'h0, 3'b000, 5'd0, 5'd0, 5'd0);
      step("burst", 1'b0, 32'h0);
    end
    check("burst_cnt", instret, 64'd5);
    drive(1'b1, 2'b00, 1'b1, 32'h0, 32'h5555AAAA, 32'h0, 3'b000, 5'd7, 5'd0, 5'd0);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_inst", instret, 64'd0);
    model_clear();
    @(posedge clk);
    #2;
    rst = 1'b0;
    wb_reg_write_en = 1'b0;
    wb_valid = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 5'd7, 5'd7);
    step("x7_dropped", 1'b0, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      drive(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
            3'($urandom), rd,
            ($urandom_range(0, 1) == 1) ? rd : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom));
      step("rand", 1'b0, 32'h0);
    end

    // Full readback from storage.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 5'd0, 5'(i), 5'(31 - i));
      step("readback", 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
